// File: rtl/uart_rx_frame_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, parity types,
// legal oversampling ratios and the 3-sample vote.
package uart_rx_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int PRESCALE_X8  = 8;
  localparam int PRESCALE_X16 = 16;
  localparam int PRESCALE_X32 = 32;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Takes three samples of the synchronised line around mid-bit and votes;
// sample_done marks the cycle where the voted bit is ready.
module uart_rx_sampler
  import uart_rx_frame_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      rx_s,
  input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      bit_val,
  output logic                      sample_done
);

  logic [PRESCALE_WIDTH-1:0] half;
  logic [2:0]                smp;

  assign half = prescale >> 1;

  always_ff @(posedge CLK) begin
    if (edge_cnt == half - PRESCALE_WIDTH'(1)) smp[0] <= rx_s;
    if (edge_cnt == half)                      smp[1] <= rx_s;
    if (edge_cnt == half + PRESCALE_WIDTH'(1)) smp[2] <= rx_s;
  end

  assign sample_done = (edge_cnt == half + PRESCALE_WIDTH'(2));
  assign bit_val     = majority3(smp);

endmodule

// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver: deserialises one frame and holds the byte with a
// level qualifier until the next start bit, for a downstream bus synchroniser.
module uart_rx_frame
  import uart_rx_frame_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid,
  output logic                      parity_error,
  output logic                      framing_error
);

  localparam int BIT_CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_t                 state;
  logic                      rx_meta;
  logic                      rx_s;
  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [PRESCALE_WIDTH-1:0] presc;
  logic [BIT_CW-1:0]         bit_cnt;
  logic                      par_en_l;
  logic                      par_typ_l;
  logic                      par_bad;
  logic [DATA_WIDTH-1:0]     shift;
  logic                      bit_val;
  logic                      sample_done;
  logic                      edge_last;
  logic                      par_exp;

  // Line synchroniser resets to idle-high so reset never looks like a start bit
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX_IN;
      rx_s    <= rx_meta;
    end
  end

  uart_rx_sampler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_sampler (
    .CLK        (CLK),
    .rx_s       (rx_s),
    .edge_cnt   (edge_cnt),
    .prescale   (presc),
    .bit_val    (bit_val),
    .sample_done(sample_done)
  );

  assign edge_last = (edge_cnt == presc - PRESCALE_WIDTH'(1));
  assign par_exp   = (^shift) ^ (par_typ_l == PAR_ODD);

  always_ff @(posedge CLK) begin
    if (state == ST_DATA && sample_done) shift <= {bit_val, shift[DATA_WIDTH-1:1]};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= ST_IDLE;
      edge_cnt      <= '0;
      bit_cnt       <= '0;
      presc         <= '0;
      par_en_l      <= 1'b0;
      par_typ_l     <= 1'b0;
      par_bad       <= 1'b0;
      P_DATA        <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          edge_cnt <= '0;
          bit_cnt  <= '0;
          if (!rx_s) begin
            state         <= ST_START;
            presc         <= PRESCALE;
            par_en_l      <= PAR_EN;
            par_typ_l     <= PAR_TYP;
            par_bad       <= 1'b0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
          end
        end
        ST_START: begin
          edge_cnt <= edge_last ? '0 : edge_cnt + PRESCALE_WIDTH'(1);
          if (sample_done && bit_val) begin
            state    <= ST_IDLE;
            edge_cnt <= '0;
          end else if (edge_last) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          edge_cnt <= edge_last ? '0 : edge_cnt + PRESCALE_WIDTH'(1);
          if (edge_last) begin
            if (bit_cnt == BIT_CW'(DATA_WIDTH - 1)) begin
              bit_cnt <= '0;
              state   <= par_en_l ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + BIT_CW'(1);
            end
          end
        end
        ST_PARITY: begin
          edge_cnt <= edge_last ? '0 : edge_cnt + PRESCALE_WIDTH'(1);
          if (sample_done) par_bad <= (bit_val != par_exp);
          if (edge_last) state <= ST_STOP;
        end
        ST_STOP: begin
          edge_cnt <= edge_last ? '0 : edge_cnt + PRESCALE_WIDTH'(1);
          // Leave at mid-stop so a short stop bit or a following start is not missed
          if (sample_done) begin
            state    <= ST_IDLE;
            edge_cnt <= '0;
            if (bit_val && !par_bad) begin
              P_DATA     <= shift;
              data_valid <= 1'b1;
            end
            if (!bit_val) framing_error <= 1'b1;
            if (par_bad)  parity_error  <= 1'b1;
          end else if (edge_last) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          edge_cnt <= '0;
        end
      endcase
    end
  end

endmodule
